image_pattern_seq: RTL and testbench

IMAGE_PATTERN_SEQ -- requirements
Module: image_pattern_seq

---
 rtl/vga_pkg.sv | 20 ++
 rtl/mode_search.sv | 31 +++
 rtl/image_pattern_seq.sv | 140 ++++++++++++++
 tb/tb_image_pattern_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing types plus the pattern sequencer state encoding.
// Imported by the timing, generator and sequencer blocks.
package vga_pkg;

  localparam int TIMING_WIDTH = 12;

  typedef struct packed {
    logic [TIMING_WIDTH-1:0] visible_area;
    logic [TIMING_WIDTH-1:0] front_porch;
    logic [TIMING_WIDTH-1:0] sync_pulse;
    logic [TIMING_WIDTH-1:0] back_porch;
  } line_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PENDING
  } seq_state_e;

endpackage

// File: rtl/mode_search.sv
// Rotate-priority search for the nearest eligible pattern index
// strictly after (dir_next=1) or before (dir_next=0) the current one.
module mode_search #(
  parameter  int MODE_WIDTH = 3,
  localparam int N_MODES    = 2**MODE_WIDTH
) (
  input  logic [MODE_WIDTH-1:0] mode,
  input  logic [N_MODES-1:0]    mask,
  input  logic                  dir_next,
  output logic [MODE_WIDTH-1:0] found,
  output logic                  none_found
);

  logic [MODE_WIDTH-1:0] idx;

  // Nearest offset wins; the current index itself is never a candidate.
  always_comb begin
    found      = mode;
    none_found = 1'b1;
    idx        = mode;
    for (int i = 1; i < N_MODES; i++) begin
      idx = dir_next ? mode + MODE_WIDTH'(i)
                     : mode - MODE_WIDTH'(i);
      if (none_found && mask[idx]) begin
        found      = idx;
        none_found = 1'b0;
      end
    end
  end

endmodule

// File: rtl/image_pattern_seq.sv
// Test-pattern sequencer: steps the generator mode on frame
// boundaries from manual next/prev, timed auto-advance or mask.
module image_pattern_seq
  import vga_pkg::*;
#(
  parameter  int MODE_WIDTH  = 3,
  parameter  int DWELL_WIDTH = 8,
  localparam int N_MODES     = 2**MODE_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  line_t                   h_line_i,
  input  line_t                   v_line_i,
  input  logic [TIMING_WIDTH-1:0] x_i,
  input  logic [TIMING_WIDTH-1:0] y_i,
  input  logic                    de_i,
  input  logic                    auto_i,
  input  logic [DWELL_WIDTH-1:0]  dwell_i,
  input  logic                    next_i,
  input  logic                    prev_i,
  input  logic [N_MODES-1:0]      mask_i,
  output logic [MODE_WIDTH-1:0]   mode_o,
  output logic                    frame_end_o,
  output logic                    pending_o
);

  seq_state_e state_q, state_d;

  logic [MODE_WIDTH-1:0]  mode_q, mode_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic                   dir_q, dir_d;
  logic                   fe_q, fe_cond;
  logic                   manual;
  logic                   auto_tick;
  logic                   auto_exp;
  logic                   mask_bad;
  logic                   step;
  logic                   step_dir;
  logic [MODE_WIDTH-1:0]  found;
  logic                   none_found;
  logic                   unused_ok;

  assign fe_cond = de_i
    && x_i == h_line_i.visible_area - TIMING_WIDTH'(1)
    && y_i == v_line_i.visible_area - TIMING_WIDTH'(1);

  assign unused_ok = ^{h_line_i.front_porch,
                       h_line_i.sync_pulse,
                       h_line_i.back_porch,
                       v_line_i.front_porch,
                       v_line_i.sync_pulse,
                       v_line_i.back_porch};

  assign manual = next_i ^ prev_i;

  // A request arriving in the boundary cycle overrides the latched one.
  assign step_dir = (state_q == PENDING)
                  ? (manual ? next_i : dir_q)
                  : 1'b1;

  mode_search #(
    .MODE_WIDTH(MODE_WIDTH)
  ) u_search (
    .mode      (mode_q),
    .mask      (mask_i),
    .dir_next  (step_dir),
    .found     (found),
    .none_found(none_found)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    auto_tick = 1'b0;
    auto_exp  = 1'b0;
    mask_bad  = 1'b0;
    step      = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          auto_tick = fe_q && auto_i && dwell_i != '0;
          // >= so a shortened dwell expires at the next boundary
          auto_exp  = auto_tick
                   && cnt_q >= dwell_i - DWELL_WIDTH'(1);
          mask_bad  = fe_q && !mask_i[mode_q];
          step      = auto_exp || mask_bad;
          if (auto_tick)
            cnt_d = auto_exp ? '0 : cnt_q + DWELL_WIDTH'(1);
          if (manual) begin
            state_d = PENDING;
            dir_d   = next_i;
          end
        end
        PENDING: begin
          if (manual) dir_d = next_i;
          if (fe_q) begin
            step    = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (step) begin
      if (!none_found)          mode_d = found;
      else if (!mask_i[mode_q]) mode_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b1;
      fe_q   <= 1'b0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      fe_q   <= fe_cond;
    end
  end

  assign mode_o      = mode_q;
  assign frame_end_o = fe_q;
  assign pending_o   = (state_q == PENDING);

endmodule

// File: tb/tb_image_pattern_seq.sv
// Scoreboard bench for image_pattern_seq on a 16x8 visible raster
// with four blanking cycles per frame.
module tb_image_pattern_seq;
  import vga_pkg::*;

  localparam int FRAME = 16 * 8 + 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    enable;
  line_t                   h_line, v_line;
  logic [TIMING_WIDTH-1:0] x, y;
  logic                    de;
  logic                    auto_en;
  logic [7:0]              dwell;
  logic                    next_p, prev_p;
  logic [7:0]              mask;
  logic [2:0]              mode;
  logic                    frame_end;
  logic                    pending;

  int    vectors    = 0;
  int    miscompares = 0;
  int    pos        = 0;
  bit    fe_prev    = 1'b0;
  int    exp_q[$];
  string name_q[$];

  image_pattern_seq dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .enable_i   (enable),
    .h_line_i   (h_line),
    .v_line_i   (v_line),
    .x_i        (x),
    .y_i        (y),
    .de_i       (de),
    .auto_i     (auto_en),
    .dwell_i    (dwell),
    .next_i     (next_p),
    .prev_i     (prev_p),
    .mask_i     (mask),
    .mode_o     (mode),
    .frame_end_o(frame_end),
    .pending_o  (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive();
    de = pos < 128;
    x  = TIMING_WIDTH'(pos % 16);
    y  = TIMING_WIDTH'(pos / 16);
  endtask

  task automatic tick();
    @(negedge clk);
    next_p = 1'b0;
    prev_p = 1'b0;
    pos = (pos + 1) % FRAME;
    drive();
  endtask

  task automatic goto_xy(input int tx, input int ty);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(x == tx && y == ty && de) && n < 2 * FRAME);
    if (n >= 2 * FRAME) check("goto timeout", 0, 1);
  endtask

  // Queue the mode expected after the coming boundary, then run to it.
  task automatic boundary(input int exp, input string nm,
                          input int exp_pend);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    goto_xy(15, 7);
    check({nm, " fe_pre"}, int'(frame_end), 0);
    tick();
    check({nm, " fe"}, int'(frame_end), 1);
    if (exp_pend >= 0) check({nm, " pend@fe"}, int'(pending), exp_pend);
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst mode", int'(mode), 0);
    check("rst pending", int'(pending), 0);
    check("rst fe", int'(frame_end), 0);
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_at(input int px, input int py,
                          input bit n, input bit p);
    goto_xy(px, py);
    next_p = n;
    prev_p = p;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (fe_prev && exp_q.size() > 0)
        check(name_q.pop_front(), int'(mode), exp_q.pop_front());
      fe_prev = frame_end;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    h_line  = '{visible_area: 16, front_porch: 4,
                sync_pulse: 8, back_porch: 4};
    v_line  = '{visible_area: 8, front_porch: 1,
                sync_pulse: 2, back_porch: 1};
    rst     = 1'b1;
    enable  = 1'b1;
    auto_en = 1'b0;
    dwell   = 8'd0;
    next_p  = 1'b0;
    prev_p  = 1'b0;
    mask    = 8'hFF;
    drive();
    do_reset();

    // single manual step
    pulse_at(3, 2, 1, 0);
    tick();
    check("next pending", int'(pending), 1);
    boundary(1, "next step", 1);
    check("next pend clr", int'(pending), 0);

    // sparse mask, wrap both ways
    do_reset();
    mask = 8'b1001_0001;
    pulse_at(3, 2, 0, 1);
    boundary(7, "prev wrap", 1);
    pulse_at(3, 2, 1, 0);
    boundary(0, "next wrap", 1);
    pulse_at(3, 2, 1, 0);
    boundary(4, "next skip", 1);
    mask = 8'hFF;

    // auto advance
    do_reset();
    auto_en = 1'b1;
    dwell   = 8'd3;
    boundary(0, "auto f1", -1);
    boundary(0, "auto f2", -1);
    boundary(1, "auto f3", -1);
    boundary(1, "auto f4", -1);
    boundary(1, "auto f5", -1);
    boundary(2, "auto f6", -1);
    dwell = 8'd0;
    for (int i = 0; i < 10; i++) boundary(2, "dwell0 hold", -1);

    // dwell shortened below count
    do_reset();
    dwell = 8'd5;
    for (int i = 0; i < 3; i++) boundary(0, "dwell5 wait", -1);
    dwell = 8'd2;
    boundary(1, "dwell shrink", -1);
    auto_en = 1'b0;
    dwell   = 8'd0;

    // simultaneous next/prev, then overwrite within a frame
    do_reset();
    pulse_at(3, 2, 1, 1);
    tick();
    check("both pending", int'(pending), 0);
    boundary(0, "both ignored", 0);
    pulse_at(1, 1, 1, 0);
    boundary(1, "to mode1", 1);
    pulse_at(1, 1, 1, 0);
    boundary(2, "to mode2", 1);
    pulse_at(3, 2, 1, 0);
    pulse_at(5, 2, 0, 1);
    tick();
    check("ovr pending", int'(pending), 1);
    boundary(1, "prev overwrite", 1);
    boundary(1, "one step only", 0);

    // mask-forced steps
    do_reset();
    mask = 8'h20;
    boundary(5, "mask to 5", -1);
    mask = 8'hFF;
    boundary(5, "mask hold 5", -1);
    mask = 8'hDF;
    boundary(6, "mask skip 5", -1);
    mask = 8'h00;
    boundary(0, "mask zero", -1);
    boundary(0, "mask zero hold", -1);
    mask = 8'h01;
    pulse_at(3, 2, 1, 0);
    boundary(0, "only eligible", 1);
    mask = 8'hFF;

    // reset during pending
    do_reset();
    mask = 8'h08;
    boundary(3, "mask to 3", -1);
    mask = 8'hFF;
    pulse_at(3, 2, 1, 0);
    tick();
    check("pre-rst pending", int'(pending), 1);
    rst = 1'b1;
    tick();
    check("mid rst mode", int'(mode), 0);
    check("mid rst pending", int'(pending), 0);
    rst = 1'b0;
    boundary(0, "req discarded", 0);

    // disabled sequencer
    mask = 8'h04;
    boundary(2, "mask to 2", -1);
    mask   = 8'hFF;
    enable = 1'b0;
    pulse_at(3, 2, 1, 0);
    tick();
    check("idle pending", int'(pending), 0);
    boundary(2, "idle hold", 0);
    enable = 1'b1;
    boundary(2, "re-enable hold", 0);

    check("queue drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
